// File: rtl/seg7_scroll_source.sv
// seg7_scroll_source: loads a 16-bit switch value into an 8-nibble display
// word on a button press and rotates it nibble-wise left or right at a
// prescaled step rate, with run/pause control and debug visibility of the
// rotation offset and FSM state.
//
// Handshake note: there is no valid/ready pair on this block. step_tick is a
// one-cycle strobe marking the cycle whose closing edge applies a rotation;
// disp_out/offset/state are registered and valid every cycle.
module seg7_scroll_source #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        run,
    input  logic        dir,
    input  logic [15:0] data_in,
    output logic [31:0] disp_out,
    output logic        step_tick,
    output logic [2:0]  offset,
    output logic [1:0]  state
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01,
        SCROLL = 2'b10,
        PAUSE  = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   word_nxt;
    logic [2:0]    off_nxt;
    logic          term;

    logic load_s1, load_s2, load_s2_d, load_rise;
    logic run_s1, run_s2;
    logic dir_s1, dir_s2;

    assign state = state_q;

    // Two-flop synchronisers for the raw pins, plus a registered rising-edge
    // pulse on load so a press lands three edges after the pin rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_s1   <= 1'b0;
            load_s2   <= 1'b0;
            load_s2_d <= 1'b0;
            load_rise <= 1'b0;
            run_s1    <= 1'b0;
            run_s2    <= 1'b0;
            dir_s1    <= 1'b0;
            dir_s2    <= 1'b0;
        end else begin
            load_s1   <= load;
            load_s2   <= load_s1;
            load_s2_d <= load_s2;
            load_rise <= load_s2 & ~load_s2_d;
            run_s1    <= run;
            run_s2    <= run_s1;
            dir_s1    <= dir;
            dir_s2    <= dir_s1;
        end
    end

    // Next-state logic: a load wins over everything, including a coincident
    // terminal count; otherwise the FSM steers the prescaler and rotation.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt;
        word_nxt  = disp_out;
        off_nxt   = offset;
        term      = (state_q == SCROLL) && (cnt == TERM);
        if (load_rise) begin
            word_nxt  = {16'h0000, data_in};
            off_nxt   = 3'd0;
            cnt_nxt   = '0;
            state_nxt = LOADED;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_nxt = '0;
                end
                LOADED: begin
                    cnt_nxt = '0;
                    if (run_s2) state_nxt = SCROLL;
                end
                SCROLL: begin
                    if (term) begin
                        cnt_nxt = '0;
                        if (dir_s2) begin
                            word_nxt = {disp_out[27:0], disp_out[31:28]};
                            off_nxt  = offset + 3'd1;
                        end else begin
                            word_nxt = {disp_out[3:0], disp_out[31:4]};
                            off_nxt  = offset - 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                    // A tick in the same cycle still rotates before pausing.
                    if (!run_s2) state_nxt = PAUSE;
                end
                PAUSE: begin
                    // Count is retained so resume continues the same period.
                    if (run_s2) state_nxt = SCROLL;
                end
            endcase
        end
    end

    // State, prescaler, word and offset registers; step_tick is registered
    // from the next-state view so it is high exactly in the terminal cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt       <= '0;
            disp_out  <= INIT_WORD;
            offset    <= 3'd0;
            step_tick <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt       <= cnt_nxt;
            disp_out  <= word_nxt;
            offset    <= off_nxt;
            step_tick <= (state_nxt == SCROLL) && (cnt_nxt == TERM);
        end
    end

endmodule
